// File: rtl/vend_motor_driver.sv
// rtl/vend_motor_driver.sv - queued, timed motor drive with drop-sensor check
// One actuation at a time; priority 1 > 2 > 3; a run without a drop latches fault.
module vend_motor_driver #(
  parameter int MIN_RUN = 4,
  parameter int TIMEOUT = 32,
  parameter int GAP     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic motor_1_req,
  input  logic motor_2_req,
  input  logic motor_3_req,
  input  logic drop_detect,
  output logic drive_1,
  output logic drive_2,
  output logic drive_3,
  output logic done_1,
  output logic done_2,
  output logic done_3,
  output logic busy,
  output logic fault,
  output logic overflow
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_RUN);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {IDLE, SPIN, GAP_S, FAULT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, gcnt, gcnt_n;
  logic [2:0]      drive_q, drive_n, done_q, done_n;
  logic [2:0]      req, take;
  logic            pend_1, pend_2, pend_1_n, pend_2_n;
  logic [2:0]      pend_3, pend_3_n;
  logic            fault_q, fault_n, ovf_q, ovf_n;
  logic [1:0]      sum_1, sum_2;
  logic [3:0]      sum_3;

  assign req = {motor_3_req, motor_2_req, motor_1_req};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    drive_n = drive_q;
    done_n  = 3'b000;
    fault_n = fault_q;
    take    = 3'b000;
    case (state)
      IDLE: begin
        if (pend_1 | req[0])                  take = 3'b001;
        else if (pend_2 | req[1])             take = 3'b010;
        else if ((pend_3 != 3'd0) | req[2])   take = 3'b100;
        if (take != 3'b000) begin
          state_n = SPIN;
          drive_n = take;
          cnt_n   = ONE_C;
        end
      end
      SPIN: begin
        cnt_n = cnt + ONE_C;
        if ((cnt >= MIN_C) && drop_detect) begin
          drive_n = 3'b000;
          done_n  = drive_q;
          state_n = GAP_S;
          gcnt_n  = ONE_C;
        end else if (cnt == TMO_C) begin
          drive_n = 3'b000;
          state_n = FAULT;
          fault_n = 1'b1;
        end
      end
      GAP_S: begin
        gcnt_n = gcnt + ONE_C;
        if (gcnt == GAP_C) state_n = IDLE;
      end
      default: begin
        drive_n = 3'b000;
      end
    endcase
  end

  // Pending entries: add the new request, subtract the one just selected; excess is lost.
  always_comb begin
    ovf_n    = ovf_q;
    sum_1    = {1'b0, pend_1} + {1'b0, req[0]} - {1'b0, take[0]};
    sum_2    = {1'b0, pend_2} + {1'b0, req[1]} - {1'b0, take[1]};
    sum_3    = {1'b0, pend_3} + {3'b000, req[2]} - {3'b000, take[2]};
    pend_1_n = |sum_1;
    pend_2_n = |sum_2;
    pend_3_n = sum_3[3] ? 3'd7 : sum_3[2:0];
    if (state_n == FAULT) begin
      pend_1_n = 1'b0;
      pend_2_n = 1'b0;
      pend_3_n = 3'd0;
    end else if (sum_1[1] | sum_2[1] | sum_3[3]) begin
      ovf_n = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      drive_q <= 3'b000;
      done_q  <= 3'b000;
      pend_1  <= 1'b0;
      pend_2  <= 1'b0;
      pend_3  <= 3'd0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      drive_q <= drive_n;
      done_q  <= done_n;
      pend_1  <= pend_1_n;
      pend_2  <= pend_2_n;
      pend_3  <= pend_3_n;
      fault_q <= fault_n;
      ovf_q   <= ovf_n;
    end
  end

  assign drive_1  = drive_q[0];
  assign drive_2  = drive_q[1];
  assign drive_3  = drive_q[2];
  assign done_1   = done_q[0];
  assign done_2   = done_q[1];
  assign done_3   = done_q[2];
  assign fault    = fault_q;
  assign overflow = ovf_q;
  assign busy     = (state == SPIN) | (state == GAP_S) | pend_1 | pend_2 | (pend_3 != 3'd0);

endmodule

// File: tb/tb_vend_motor_driver.sv
// tb/tb_vend_motor_driver.sv - random stimulus against a counting reference model
// Model tracks queue depths, the active motor and remaining gap cycles as integers.
module tb_vend_motor_driver;

  localparam int MIN_RUN = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  logic clock = 1'b0;
  logic reset, motor_1_req, motor_2_req, motor_3_req, drop_detect;
  logic drive_1, drive_2, drive_3, done_1, done_2, done_3, busy, fault, overflow;

  always #5 clock = ~clock;

  vend_motor_driver #(.MIN_RUN(MIN_RUN), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clock(clock), .reset(reset),
    .motor_1_req(motor_1_req), .motor_2_req(motor_2_req), .motor_3_req(motor_3_req),
    .drop_detect(drop_detect),
    .drive_1(drive_1), .drive_2(drive_2), .drive_3(drive_3),
    .done_1(done_1), .done_2(done_2), .done_3(done_3),
    .busy(busy), .fault(fault), .overflow(overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  int   pend[3];
  int   cap[3] = '{1, 1, 7};
  int   active, run_len, gap_left;
  bit   faulted, m_ovf;
  logic [2:0] m_done;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pend[k] = 0;
    active = -1; run_len = 0; gap_left = 0;
    faulted = 0; m_ovf = 0; m_done = 3'b000;
  endtask

  task automatic model_step();
    logic [2:0] rq;
    int took;
    rq = {motor_3_req, motor_2_req, motor_1_req};
    took = -1;
    m_done = 3'b000;
    if (reset) begin
      model_reset();
      return;
    end
    if (faulted) return;
    if (active >= 0) begin
      if (run_len >= MIN_RUN && drop_detect) begin
        m_done[active] = 1'b1;
        active = -1;
        gap_left = GAP;
      end else if (run_len == TIMEOUT) begin
        active = -1;
        faulted = 1;
        for (int k = 0; k < 3; k++) pend[k] = 0;
        return;
      end else begin
        run_len++;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else begin
      for (int k = 0; k < 3; k++)
        if (took < 0 && (pend[k] > 0 || rq[k])) took = k;
      if (took >= 0) begin
        active = took;
        run_len = 1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      pend[k] = pend[k] + int'(rq[k]) - ((took == k) ? 1 : 0);
      if (pend[k] > cap[k]) begin
        pend[k] = cap[k];
        m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] m_drive;
    logic m_busy;
    m_drive = (active >= 0) ? 3'(1 << active) : 3'b000;
    m_busy  = (active >= 0) || (gap_left > 0) || (pend[0] + pend[1] + pend[2] > 0);
    check_eq("drive", {5'b0, drive_3, drive_2, drive_1}, {5'b0, m_drive});
    check_eq("done", {5'b0, done_3, done_2, done_1}, {5'b0, m_done});
    check_eq("busy", {7'b0, busy}, {7'b0, m_busy});
    check_eq("fault", {7'b0, fault}, {7'b0, faulted});
    check_eq("overflow", {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  // drop_mode: 0 held low, 1 held high, 2 random; rst_pm in per-mille
  task automatic apply(input int n, input int req_pct, input int drop_mode, input int rst_pm);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset       = ($urandom_range(0, 999) < rst_pm);
      motor_1_req = ($urandom_range(0, 99) < req_pct);
      motor_2_req = ($urandom_range(0, 99) < req_pct);
      motor_3_req = ($urandom_range(0, 99) < req_pct);
      case (drop_mode)
        0:       drop_detect = 1'b0;
        1:       drop_detect = 1'b1;
        default: drop_detect = ($urandom_range(0, 2) == 0);
      endcase
      @(posedge clock);
      model_step();
      #1;
      compare_all();
    end
  endtask

  initial begin
    reset = 1'b1;
    motor_1_req = 1'b0; motor_2_req = 1'b0; motor_3_req = 1'b0; drop_detect = 1'b0;
    model_reset();
    apply(3, 20, 2, 1000);
    apply(400, 10, 2, 0);
    apply(1, 0, 0, 1000);
    apply(300, 8, 2, 4);
    apply(1, 0, 0, 1000);
    apply(200, 25, 1, 0);
    apply(80, 10, 0, 0);
    apply(2, 0, 0, 1000);
    apply(300, 15, 2, 6);
    apply(200, 40, 2, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
